// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding imem read, holds the fetched word until the decoder accepts it.
// Optional macro FETCH_ALIGN_CHK_EN adds AlignFault and a sticky S_FAULT state on misaligned branch targets.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        dec_ready,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [3:0]  Cond,
    output logic [1:0]  Op,
    output logic [5:0]  Funct,
    output logic [3:0]  Rd,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic [15:0] FetchCount
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic        AlignFault
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
`ifdef FETCH_ALIGN_CHK_EN
        ,
        S_FAULT = 2'd3
`endif
    } state_e;

    state_e      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [15:0] count_q;
    logic        req_q;
    logic        valid_q;

    // Masking the low bits keeps a redirect word-aligned when no fault checking is built in.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (PCSrc) begin
            fetch_pc_d = BranchTarget & 32'hFFFF_FFFC;
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    logic align_fault_q;
    logic misaligned_br;

    assign misaligned_br = PCSrc && (BranchTarget[1:0] != 2'b00);
    assign AlignFault    = align_fault_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            instr_q    <= 32'h0;
            pc_q       <= 32'h0;
            count_q    <= 16'h0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            align_fault_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_q   <= 1'b1;
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        instr_q    <= imem_rdata;
                        pc_q       <= fetch_pc_q;
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        req_q      <= 1'b0;
                        valid_q    <= 1'b1;
                        state_q    <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (dec_ready) begin
                        count_q <= count_q + 16'd1;
                        valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
                        if (misaligned_br) begin
                            align_fault_q <= 1'b1;
                            state_q       <= S_FAULT;
                        end else begin
                            fetch_pc_q <= fetch_pc_d;
                            req_q      <= 1'b1;
                            state_q    <= S_REQ;
                        end
`else
                        fetch_pc_q <= fetch_pc_d;
                        req_q      <= 1'b1;
                        state_q    <= S_REQ;
`endif
                    end
                end
`ifdef FETCH_ALIGN_CHK_EN
                S_FAULT: begin
                    state_q <= S_FAULT;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = fetch_pc_q;
    assign InstrValid = valid_q;
    assign Instr      = instr_q;
    assign Cond       = instr_q[31:28];
    assign Op         = instr_q[27:26];
    assign Funct      = instr_q[25:20];
    assign Rd         = instr_q[15:12];
    assign PC         = pc_q;
    assign PCPlus8    = pc_q + 32'd8;
    assign FetchCount = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed steps plus a randomized fetch/accept stream
// checked against a transaction-level model of the fetch address, held word and accept count.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dec_ready;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [3:0]  Cond;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rd;
    logic [31:0] PC;
    logic [31:0] PCPlus8;
    logic [15:0] FetchCount;
`ifdef FETCH_ALIGN_CHK_EN
    logic        AlignFault;
`endif

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .dec_ready    (dec_ready),
        .PCSrc        (PCSrc),
        .BranchTarget (BranchTarget),
        .InstrValid   (InstrValid),
        .Instr        (Instr),
        .Cond         (Cond),
        .Op           (Op),
        .Funct        (Funct),
        .Rd           (Rd),
        .PC           (PC),
        .PCPlus8      (PCPlus8),
        .FetchCount   (FetchCount)
`ifdef FETCH_ALIGN_CHK_EN
        ,
        .AlignFault   (AlignFault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: next fetch address, last fetched word/address, accepted count.
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [15:0] exp_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_held(input string tag);
        check({tag, "_valid"}, {31'h0, InstrValid}, 32'h1);
        check({tag, "_instr"}, Instr, exp_instr);
        check({tag, "_pc"}, PC, exp_pc);
        check({tag, "_pcplus8"}, PCPlus8, exp_pc + 32'd8);
        check({tag, "_fields"}, {Cond, Op, Funct, Rd}, {exp_instr[31:28], exp_instr[27:26],
                                                       exp_instr[25:20], exp_instr[15:12]});
        check({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    endtask

    // Serve one request as the memory, acking after `delay` idle cycles.
    task automatic do_fetch(input int delay, input logic [31:0] word);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", {31'h0, imem_req}, 32'h1);
        check("req_addr", imem_addr, exp_addr);
        for (int i = 0; i < delay; i++) begin
            PCSrc        = 1'($urandom);
            BranchTarget = $urandom;
            tick();
            check("req_hold", {imem_req, imem_addr}, {1'b1, exp_addr});
            check("req_no_valid", {31'h0, InstrValid}, 32'h0);
        end
        PCSrc      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        exp_instr  = word;
        exp_pc     = exp_addr;
        exp_addr   = exp_addr + 32'd4;
        check_held("fetched");
    endtask

    // Hold the word for `wait_cyc` cycles (optionally with stray acks), then accept it.
    task automatic accept(input int wait_cyc, input logic br, input logic [31:0] bt, input logic stray);
        for (int i = 0; i < wait_cyc; i++) begin
            PCSrc        = 1'($urandom);
            BranchTarget = $urandom;
            imem_ack     = stray;
            imem_rdata   = $urandom;
            tick();
            imem_ack = 1'b0;
            check_held("hold");
            check("hold_count", {16'h0, FetchCount}, {16'h0, exp_count});
        end
        dec_ready    = 1'b1;
        PCSrc        = br;
        BranchTarget = bt;
        tick();
        dec_ready = 1'b0;
        PCSrc     = 1'b0;
        exp_count = exp_count + 16'd1;
        if (br) exp_addr = {bt[31:2], 2'b00};
        check("acc_valid", {31'h0, InstrValid}, 32'h0);
        check("acc_req", {31'h0, imem_req}, 32'h1);
        check("acc_addr", imem_addr, exp_addr);
        check("acc_count", {16'h0, FetchCount}, {16'h0, exp_count});
    endtask

    logic        r_br;
    logic [31:0] r_bt;

    initial begin
        reset        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        dec_ready    = 1'b0;
        PCSrc        = 1'b0;
        BranchTarget = 32'h0;
        repeat (2) tick();

        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", {31'h0, InstrValid}, 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_pc", PC, 32'h0);
        check("rst_count", {16'h0, FetchCount}, 32'h0);
`ifdef FETCH_ALIGN_CHK_EN
        check("rst_fault", {31'h0, AlignFault}, 32'h0);
`endif

        reset     = 1'b1;
        exp_addr  = RST_PC;
        exp_count = 16'h0;
        check("idle_no_req", {31'h0, imem_req}, 32'h0);
        tick();
        check("req_after_idle", {imem_req, imem_addr}, {1'b1, 32'h100});

        // First fetch acked after two cycles, then held five cycles without acceptance.
        do_fetch(2, 32'hE280_1005);
        check("first_pc", PC, 32'h100);
        check("first_pcplus8", PCPlus8, 32'h108);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold5_instr", Instr, 32'hE280_1005);
            check("hold5_fields", {Cond, Op, Funct, Rd}, {4'hE, 2'b00, 6'b101000, 4'h1});
            check("hold5_req", {31'h0, imem_req}, 32'h0);
            check("hold5_count", {16'h0, FetchCount}, 32'h0);
        end

        accept(0, 1'b1, 32'h200, 1'b0);
        do_fetch(1, $urandom);
        check("pc_200", PC, 32'h200);
        accept(1, 1'b1, 32'h40, 1'b1);
        check("branch_40", {imem_addr, FetchCount}, {32'h40, 16'd2});

        do_fetch(0, $urandom);
        accept(0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        do_fetch(3, $urandom);
        accept(2, 1'b0, 32'h0, 1'b0);
        check("wrap_addr", imem_addr, 32'h0);

        for (int t = 0; t < 40; t++) begin
            r_br = ($urandom_range(0, 2) == 0);
            r_bt = $urandom;
`ifdef FETCH_ALIGN_CHK_EN
            r_bt[1:0] = 2'b00;
`endif
            do_fetch($urandom_range(0, 3), $urandom);
            accept($urandom_range(0, 3), r_br, r_bt, 1'($urandom_range(0, 1)));
        end

        // Reset while a request is pending; acks during and just after reset are ignored.
        check("pre_reset_req", {31'h0, imem_req}, 32'h1);
        reset    = 1'b0;
        imem_ack = 1'b1;
        #1;
        check("rst_mid_req", {31'h0, imem_req}, 32'h0);
        check("rst_mid_valid", {31'h0, InstrValid}, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("refetch_valid", {31'h0, InstrValid}, 32'h0);
        check("refetch_req", {imem_req, imem_addr}, {1'b1, RST_PC});
        check("refetch_state", {Instr, PC}, {32'h0, 32'h0});
        exp_addr  = RST_PC;
        exp_count = 16'h0;

        do_fetch(1, $urandom);
        dec_ready    = 1'b1;
        PCSrc        = 1'b1;
        BranchTarget = 32'h42;
        tick();
        dec_ready = 1'b0;
        PCSrc     = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        check("fault_set", {31'h0, AlignFault}, 32'h1);
        check("fault_valid", {31'h0, InstrValid}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            tick();
            check("fault_no_req", {imem_req, InstrValid, AlignFault}, {1'b0, 1'b0, 1'b1});
        end
        imem_ack = 1'b0;
`else
        check("misalign_addr", {imem_req, imem_addr}, {1'b1, 32'h40});
        check("misalign_count", {16'h0, FetchCount}, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; SHALL be the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; SHALL clear all state immediately when low.
REQ-004 imem_req  output  1  instruction memory read request.
REQ-005 imem_addr  output  32  word address of the pending request.
REQ-006 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 dec_ready  input  1  control unit/datapath accepts the held instruction this cycle.
REQ-009 PCSrc  input  1  branch taken; sampled only on acceptance.
REQ-010 BranchTarget  input  32  next fetch address when PCSrc is set.
REQ-011 InstrValid  output  1  Instr and the decoded fields are valid.
REQ-012 Instr  output  32  held instruction word.
REQ-013 Cond, Op, Funct, Rd  output  4/2/6/4  Instr[31:28], Instr[27:26], Instr[25:20], Instr[15:12]; SHALL be combinational slices of Instr.
REQ-014 PC  output  32  address of Instr; PCPlus8 output 32 SHALL equal PC+8 modulo 2^32.
REQ-015 FetchCount  output  16  count of accepted instructions.

Function
REQ-016 FSM states SHALL be S_IDLE, S_REQ, S_VALID and, when configured, S_FAULT.
REQ-017 S_IDLE SHALL last exactly one cycle after reset deassertion, then go to S_REQ.
REQ-018 In S_REQ, imem_req SHALL be 1 and imem_addr SHALL equal fetch_pc, held stable until imem_ack.
REQ-019 On imem_ack in S_REQ: Instr<=imem_rdata, PC<=fetch_pc, fetch_pc<=fetch_pc+4 (wrapping 32'hFFFF_FFFC to 0), next state S_VALID; imem_req SHALL be 0 the following cycle.
REQ-020 Latency: ack in cycle N SHALL give InstrValid=1 in cycle N+1.
REQ-021 Only one request SHALL be outstanding; imem_ack outside S_REQ SHALL be ignored.
REQ-022 In S_VALID: InstrValid=1, and Instr, PC and fields SHALL hold until dec_ready=1.
REQ-023 Acceptance (S_VALID and dec_ready): FetchCount SHALL increment, wrapping 16'hFFFF to 0, and next state SHALL be S_REQ.
REQ-024 On acceptance with PCSrc=1, fetch_pc SHALL load BranchTarget, overriding the sequential fetch_pc.
REQ-025 PCSrc and BranchTarget SHALL be ignored while InstrValid=0.

Reset
REQ-026 While reset=0: imem_req=0, imem_addr=RESET_PC, InstrValid=0, Instr=0, PC=0, FetchCount=0, AlignFault=0, state S_IDLE, fetch_pc=RESET_PC.
REQ-027 Reset asserted mid-request SHALL drop imem_req in the same cycle, and a late imem_ack SHALL be ignored.

Configuration
REQ-028 Macro FETCH_ALIGN_CHK_EN: when defined, output AlignFault (1 bit) SHALL exist, and an acceptance with PCSrc=1 and BranchTarget[1:0]!=0 SHALL set sticky AlignFault and enter S_FAULT (no requests, InstrValid=0) until reset.
REQ-029 Without FETCH_ALIGN_CHK_EN: there SHALL be no AlignFault port, and fetch_pc SHALL load {BranchTarget[31:2],2'b00}.

Verification
REQ-030 Release reset with RESET_PC=32'h100 and ack after 2 cycles -> imem_addr=32'h100; InstrValid=1 one cycle after ack; PC=32'h100; PCPlus8=32'h108.
REQ-031 Instr=32'hE280_1005 held with dec_ready=0 for 5 cycles -> Instr, Cond=4'hE, Op=2'b00, Funct=6'b101000, Rd=4'h1 stable; imem_req=0; FetchCount unchanged.
REQ-032 Accept at PC=32'h200 with PCSrc=1, BranchTarget=32'h40 -> next imem_addr=32'h40; FetchCount+1.
REQ-033 fetch_pc=32'hFFFF_FFFC, fetched and accepted -> next imem_addr=32'h0.
REQ-034 Drive reset=0 while imem_req=1, then ack one cycle later -> imem_req=0 immediately; InstrValid stays 0; refetch from RESET_PC.
REQ-035 With FETCH_ALIGN_CHK_EN, branch to 32'h42 -> AlignFault=1 and no further imem_req; without the macro -> imem_addr=32'h40.
